// File: rtl/serial_ripple_sub.sv
// Bit-serial ripple-borrow subtractor: D = (A - B - Bin) mod 2^WIDTH, one bit per clock
// through a single full-subtractor cell, behind a start/busy/done handshake.
module serial_ripple_sub #(
  parameter int WIDTH = 4,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] ra, rb, rd, rd_next;
  logic [CW-1:0]    cnt;
  logic             br, am, bm;
  logic             abit, bbit, dbit, br_next, last, accept;

  // Full-subtractor cell on the current LSBs plus the registered borrow.
  always_comb begin
    abit    = ra[0];
    bbit    = rb[0];
    dbit    = abit ^ bbit ^ br;
    br_next = (~abit & bbit) | (~(abit ^ bbit) & br);
    rd_next = {dbit, rd[WIDTH-1:1]};
    last    = (cnt == CW'(WIDTH - 1));
    accept  = start && (state != SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last)   state_next = DONE;
      DONE:    state_next = accept ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // Operand MSBs are kept separately because ra/rb are consumed by the shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra   <= '0;
      rb   <= '0;
      rd   <= '0;
      br   <= 1'b0;
      am   <= 1'b0;
      bm   <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      Bout <= 1'b0;
      V    <= 1'b0;
    end else if (accept) begin
      ra  <= A;
      rb  <= B;
      br  <= Bin;
      am  <= A[WIDTH-1];
      bm  <= B[WIDTH-1];
      rd  <= '0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      rd  <= rd_next;
      br  <= br_next;
      cnt <= cnt + CW'(1);
      if (last) begin
        D    <= rd_next;
        Bout <= br_next;
        V    <= (am != bm) && (dbit != am);
      end
    end
  end

endmodule

// File: tb/tb_serial_ripple_sub.sv
// Self-checking bench for serial_ripple_sub: arithmetic reference model checked every
// cycle, plus hand-computed literal expectations for the directed vectors.
module tb_serial_ripple_sub;
  localparam int WIDTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0, B = '0;
  logic             Bin = 1'b0;
  logic             busy, done, Bout, V;
  logic [WIDTH-1:0] D;

  int checks = 0;
  int errors = 0;

  serial_ripple_sub #(.WIDTH(WIDTH), .CW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .D(D), .Bout(Bout), .V(V)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: unsigned difference, borrow by comparison, V from sign bits.
  function automatic int ref_d(input int a, input int b, input int bi);
    return (a - b - bi) & MASK;
  endfunction
  function automatic int ref_bout(input int a, input int b, input int bi);
    return (a < b + bi) ? 1 : 0;
  endfunction
  function automatic int ref_v(input int a, input int b, input int bi);
    int d, sa, sb, sd;
    d  = ref_d(a, b, bi);
    sa = (a >> (WIDTH - 1)) & 1;
    sb = (b >> (WIDTH - 1)) & 1;
    sd = (d >> (WIDTH - 1)) & 1;
    return (sa != sb && sd != sa) ? 1 : 0;
  endfunction

  // Cycle-level job model: a job occupies WIDTH busy cycles, then one done cycle.
  int m_left, m_done, m_d, m_bout, m_v, ja, jb, jbin;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0; m_done <= 0; m_d <= 0; m_bout <= 0; m_v <= 0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      m_done <= 0;
      if (m_left == 1) begin
        m_done <= 1;
        m_d    <= ref_d(ja, jb, jbin);
        m_bout <= ref_bout(ja, jb, jbin);
        m_v    <= ref_v(ja, jb, jbin);
      end
    end else begin
      m_done <= 0;
      if (start) begin
        ja <= int'(A); jb <= int'(B); jbin <= int'(Bin);
        m_left <= WIDTH;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", int'(busy), (m_left != 0) ? 1 : 0);
      chk("done", int'(done), m_done);
      chk("D",    int'(D),    m_d);
      chk("Bout", int'(Bout), m_bout);
      chk("V",    int'(V),    m_v);
    end
  end

  task automatic issue(input int a, input int b, input int bi);
    @(posedge clk); #1;
    A = WIDTH'(a); B = WIDTH'(b); Bin = bi[0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; returns number of busy cycles observed on the way.
  task automatic wait_done(output int busy_cycles, output bit ok);
    busy_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      if (busy) busy_cycles++;
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic job_lit(input int a, input int b, input int bi,
                         input int ed, input int eb, input int ev, input string tag);
    int bc; bit ok;
    issue(a, b, bi);
    wait_done(bc, ok);
    if (ok) begin
      chk({tag, "_D"}, int'(D), ed);
      chk({tag, "_Bout"}, int'(Bout), eb);
      chk({tag, "_V"}, int'(V), ev);
    end
  endtask

  initial begin
    int bc, n;
    bit ok;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_D", int'(D), 0);
    chk("rst_Bout", int'(Bout), 0);
    chk("rst_V", int'(V), 0);
    #20 rst = 1'b0;

    job_lit(0, 0, 0, 4'b0000, 0, 0, "zero");
    job_lit(4'b1000, 4'b0011, 0, 4'b0101, 0, 1, "8m3");

    issue(4'b0011, 4'b0101, 0);
    wait_done(bc, ok);
    chk("3m5_busy_cycles", bc, WIDTH);
    if (ok) begin
      chk("3m5_D", int'(D), 4'b1110);
      chk("3m5_Bout", int'(Bout), 1);
      chk("3m5_V", int'(V), 0);
      @(negedge clk);
      chk("done_single_pulse", int'(done), 0);
    end

    job_lit(4'b0101, 4'b0101, 1, 4'b1111, 1, 0, "5m5b");
    job_lit(4'b1111, 4'b0001, 0, 4'b1110, 0, 0, "15m1");

    // Second start while busy must be ignored.
    issue(4'b0110, 4'b0010, 0);
    @(posedge clk); #1;
    A = 4'b0001; B = 4'b1001; Bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(bc, ok);
    if (ok) chk("ignored_D", int'(D), 4'b0100);

    // Restart inside the DONE cycle.
    A = 4'b1001; B = 4'b0100; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      if (i != 0 || 1) @(negedge clk);
      n++;
      if (done) begin ok = 1'b1; break; end
    end
    chk("b2b_latency", n, WIDTH + 1);
    if (ok) chk("b2b_D", int'(D), 4'b0101);

    // Asynchronous reset mid-SHIFT.
    issue(4'b1100, 4'b0001, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_D", int'(D), 0);
    chk("arst_Bout", int'(Bout), 0);
    chk("arst_V", int'(V), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(negedge clk);
      chk("arst_no_done", int'(done), 0);
    end
    job_lit(4'b0111, 4'b1000, 0, 4'b1111, 1, 1, "post_rst");

    // Exhaustive sweep; the per-cycle model checks D/Bout/V, and adding back recovers A.
    for (int a = 0; a <= MASK; a++)
      for (int b = 0; b <= MASK; b++)
        for (int bi = 0; bi < 2; bi++) begin
          issue(a, b, bi);
          wait_done(bc, ok);
          if (ok) chk("adder_recovers_A", (int'(D) + b + bi) & MASK, a);
        end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
